// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for the five-stage pipeline. Resolves, in
// fixed priority order:
//   1. a memory-stage exception redirect (flush IF/ID, ID/EXE, EXE/MEM),
//   2. a multi-cycle DIV/DIVU occupying EXE (stall front end, hold ID/EXE,
//      bubble into MEM),
//   3. a load-use hazard between EXE and ID (stall front end, bubble into EXE).
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined     -> three wrapping performance counters are implemented
//   not defined -> counter registers are absent and the outputs read 0
//
// Parameters
//   DIV_CYCLES  total cycles a divide occupies EXE (2..255)
//   CNT_W       performance counter width
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-low reset
//   ID_rs, ID_rt             source registers of the instruction in ID
//   EXE_ReadMem, EXE_Dst     load flag / destination of the instruction in EXE
//   EXE_DivReq               DIV/DIVU in EXE (level)
//   MEM_ExceptType_new       exception vector of the instruction in MEM
//   IF_PCWr, IF_IDWr         PC / IF-ID write enables
//   IFID_Flush, IDEXE_Flush, EXEMEM_Flush   per-stage clears
//   EXE_Hold                 ID/EXE keeps its contents
//   Exc_Redirect             PC mux selects the exception vector
//   Div_Busy, Div_Done       divide sequencer status
//   Perf_*Cnt                performance counters
//   dbg_state                current sequencer state (0 = RUN, 1 = DIV_BUSY)
//
// Handshake: there is no valid/ready pair here; every control output is a
// level that applies to the pipeline registers at the next rising edge.
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             EXE_ReadMem,
  input  logic [4:0]       EXE_Dst,
  input  logic             EXE_DivReq,
  input  logic [8:0]       MEM_ExceptType_new,
  output logic             IF_PCWr,
  output logic             IF_IDWr,
  output logic             IFID_Flush,
  output logic             IDEXE_Flush,
  output logic             EXEMEM_Flush,
  output logic             EXE_Hold,
  output logic             Exc_Redirect,
  output logic             Div_Busy,
  output logic             Div_Done,
  output logic [CNT_W-1:0] Perf_LoadUseCnt,
  output logic [CNT_W-1:0] Perf_DivCnt,
  output logic [CNT_W-1:0] Perf_ExcCnt,
  output logic             dbg_state
);

  typedef enum logic {
    RUN      = 1'b0,
    DIV_BUSY = 1'b1
  } state_t;

  // The first stall cycle happens in RUN, so DIV_BUSY only needs to count
  // the remaining DIV_CYCLES-2 stall cycles before the done cycle.
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

  state_t     state, next_state;
  logic [7:0] cnt, next_cnt;

  // Decoded events for this cycle (only meaningful while rst=1).
  logic exc_take;
  logic div_stall;
  logic div_done;
  logic lu_stall;
  logic lu_hit;

  assign lu_hit = EXE_ReadMem && (EXE_Dst != 5'd0) &&
                  ((EXE_Dst == ID_rs) || (EXE_Dst == ID_rt));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    exc_take   = 1'b0;
    div_stall  = 1'b0;
    div_done   = 1'b0;
    lu_stall   = 1'b0;

    if (|MEM_ExceptType_new) begin
      // Abandons any in-flight divide.
      exc_take   = 1'b1;
      next_state = RUN;
      next_cnt   = 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (EXE_DivReq) begin
            div_stall  = 1'b1;
            next_state = DIV_BUSY;
            next_cnt   = DIV_LOAD;
          end else if (lu_hit) begin
            lu_stall = 1'b1;
          end
        end
        DIV_BUSY: begin
          // EXE_DivReq is ignored here; the divide in EXE is already counted.
          if (cnt != 8'd0) begin
            div_stall = 1'b1;
            next_cnt  = cnt - 8'd1;
          end else begin
            div_done   = 1'b1;
            next_state = RUN;
          end
        end
        default: begin
          next_state = RUN;
          next_cnt   = 8'd0;
        end
      endcase
    end
  end

  // While rst=0 the pipeline is frozen and all stage registers are cleared.
  assign IF_PCWr      = rst & ~div_stall & ~lu_stall;
  assign IF_IDWr      = rst & ~div_stall & ~lu_stall;
  assign IFID_Flush   = ~rst | exc_take;
  assign IDEXE_Flush  = ~rst | exc_take | lu_stall;
  assign EXEMEM_Flush = ~rst | exc_take | div_stall;
  assign EXE_Hold     = rst & div_stall;
  assign Exc_Redirect = rst & exc_take;
  assign Div_Busy     = rst & (state == DIV_BUSY);
  assign Div_Done     = rst & div_done;
  assign dbg_state    = state;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      Perf_LoadUseCnt <= '0;
      Perf_DivCnt     <= '0;
      Perf_ExcCnt     <= '0;
    end else begin
      if (lu_stall)  Perf_LoadUseCnt <= Perf_LoadUseCnt + 1'b1;
      if (div_stall) Perf_DivCnt     <= Perf_DivCnt + 1'b1;
      if (exc_take)  Perf_ExcCnt     <= Perf_ExcCnt + 1'b1;
    end
  end
`else
  assign Perf_LoadUseCnt = '0;
  assign Perf_DivCnt     = '0;
  assign Perf_ExcCnt     = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed scenarios followed by random stimulus. Each driven cycle computes
// the expected control outputs and counter values from a behavioural model
// (remaining-divide-cycles counter plus event counts) and pushes them into
// exp_q; a monitor on the falling edge pops and compares against the DUT.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int DIV_CYCLES = 4;
  localparam int CNT_W      = 32;
  localparam int W          = 9 + 3 * CNT_W;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b0;
  logic [4:0]       ID_rs = '0, ID_rt = '0, EXE_Dst = '0;
  logic             EXE_ReadMem = 1'b0, EXE_DivReq = 1'b0;
  logic [8:0]       MEM_ExceptType_new = '0;
  logic             IF_PCWr, IF_IDWr, IFID_Flush, IDEXE_Flush, EXEMEM_Flush;
  logic             EXE_Hold, Exc_Redirect, Div_Busy, Div_Done, dbg_state;
  logic [CNT_W-1:0] Perf_LoadUseCnt, Perf_DivCnt, Perf_ExcCnt;

  pipe_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .EXE_ReadMem(EXE_ReadMem), .EXE_Dst(EXE_Dst), .EXE_DivReq(EXE_DivReq),
    .MEM_ExceptType_new(MEM_ExceptType_new),
    .IF_PCWr(IF_PCWr), .IF_IDWr(IF_IDWr),
    .IFID_Flush(IFID_Flush), .IDEXE_Flush(IDEXE_Flush), .EXEMEM_Flush(EXEMEM_Flush),
    .EXE_Hold(EXE_Hold), .Exc_Redirect(Exc_Redirect),
    .Div_Busy(Div_Busy), .Div_Done(Div_Done),
    .Perf_LoadUseCnt(Perf_LoadUseCnt), .Perf_DivCnt(Perf_DivCnt), .Perf_ExcCnt(Perf_ExcCnt),
    .dbg_state(dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // reference model state
  int m_div_left = 0;     // cycles of the current divide still to come, incl. done cycle
  int unsigned m_lu = 0, m_div = 0, m_exc = 0;

  // driver: apply one cycle of inputs, predict, push expectation, advance model
  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rm, input logic [4:0] dst, input logic dq,
                       input logic [8:0] ex);
    logic pcwr, idwr, f1, f2, f3, hold, redir, busy, done;
    logic [CNT_W-1:0] c_lu, c_div, c_exc;
    @(posedge clk);
    #1;
    rst = r; ID_rs = rs; ID_rt = rt; EXE_ReadMem = rm; EXE_Dst = dst;
    EXE_DivReq = dq; MEM_ExceptType_new = ex;
`ifdef HAZARD_PERF_CNT_EN
    c_lu = CNT_W'(m_lu); c_div = CNT_W'(m_div); c_exc = CNT_W'(m_exc);
`else
    c_lu = '0; c_div = '0; c_exc = '0;
`endif
    if (!r) begin
      {pcwr, idwr, f1, f2, f3, hold, redir, busy, done} = 9'b00_111_0000;
      m_div_left = 0; m_lu = 0; m_div = 0; m_exc = 0;
    end else begin
      {pcwr, idwr, f1, f2, f3, hold, redir, busy, done} = 9'b11_000_0000;
      busy = (m_div_left != 0);
      if (ex != 9'd0) begin
        redir = 1; f1 = 1; f2 = 1; f3 = 1;
        m_exc++; m_div_left = 0;
      end else if (m_div_left == 0 && dq) begin
        pcwr = 0; idwr = 0; hold = 1; f3 = 1;
        m_div++; m_div_left = DIV_CYCLES - 1;
      end else if (m_div_left > 1) begin
        pcwr = 0; idwr = 0; hold = 1; f3 = 1;
        m_div++; m_div_left--;
      end else if (m_div_left == 1) begin
        done = 1; m_div_left = 0;
      end else if (rm && dst != 0 && (dst == rs || dst == rt)) begin
        pcwr = 0; idwr = 0; f2 = 1;
        m_lu++;
      end
    end
    exp_q.push_back({pcwr, idwr, f1, f2, f3, hold, redir, busy, done, c_lu, c_div, c_exc});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 9'd0);
  endtask

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [8:0]   act_f;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      act_f = {IF_PCWr, IF_IDWr, IFID_Flush, IDEXE_Flush, EXEMEM_Flush,
               EXE_Hold, Exc_Redirect, Div_Busy, Div_Done};
      checks++;
      if (act_f !== e[W-1 -: 9]) begin
        errors++;
        $display("FAIL ctrl t=%0t act=%b exp=%b (pcwr idwr ifid idexe exemem hold redir busy done)",
                 $time, act_f, e[W-1 -: 9]);
      end
      checks++;
      if ({Perf_LoadUseCnt, Perf_DivCnt, Perf_ExcCnt} !== e[3*CNT_W-1:0]) begin
        errors++;
        $display("FAIL perf t=%0t act=%0d/%0d/%0d exp=%0d/%0d/%0d", $time,
                 Perf_LoadUseCnt, Perf_DivCnt, Perf_ExcCnt,
                 e[3*CNT_W-1 -: CNT_W], e[2*CNT_W-1 -: CNT_W], e[CNT_W-1:0]);
      end
    end
  end

  initial begin
    // reset state
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 9'd0);
    idle(2);
    // load-use on rt, then r0 destination, then rs
    drive(1, 5'd1, 5'd5, 1, 5'd5, 0, 9'd0);
    drive(1, 5'd1, 5'd0, 1, 5'd0, 0, 9'd0);
    drive(1, 5'd7, 5'd2, 1, 5'd7, 0, 9'd0);
    drive(1, 5'd7, 5'd2, 0, 5'd7, 0, 9'd0);   // not a load
    idle(1);
    // single divide, request held while in EXE
    for (int i = 0; i < DIV_CYCLES; i++) drive(1, 0, 0, 0, 0, 1, 9'd0);
    idle(2);
    // back-to-back divides
    for (int i = 0; i < 2 * DIV_CYCLES; i++) drive(1, 0, 0, 0, 0, 1, 9'd0);
    idle(2);
    // exception mid-divide
    drive(1, 0, 0, 0, 0, 1, 9'd0);
    drive(1, 0, 0, 0, 0, 1, 9'h010);
    idle(4);
    // load-use together with exception
    drive(1, 5'd3, 5'd0, 1, 5'd3, 0, 9'h001);
    idle(1);
    // load-use during DIV_BUSY
    drive(1, 0, 0, 0, 0, 1, 9'd0);
    drive(1, 5'd3, 5'd0, 1, 5'd3, 1, 9'd0);
    drive(1, 5'd3, 5'd0, 1, 5'd3, 1, 9'd0);
    drive(1, 5'd3, 5'd0, 1, 5'd3, 1, 9'd0);
    idle(1);
    // exception in the done cycle
    for (int i = 0; i < DIV_CYCLES - 1; i++) drive(1, 0, 0, 0, 0, 1, 9'd0);
    drive(1, 0, 0, 0, 0, 1, 9'h100);
    idle(1);
    // reset mid-divide, then a full divide
    drive(1, 0, 0, 0, 0, 1, 9'd0);
    drive(0, 0, 0, 0, 0, 1, 9'd0);
    drive(1, 0, 0, 0, 0, 0, 9'd0);
    for (int i = 0; i < DIV_CYCLES; i++) drive(1, 0, 0, 0, 0, 1, 9'd0);
    idle(1);
    // random
    for (int i = 0; i < 3000; i++) begin
      logic       r, rm, dq;
      logic [4:0] rs, rt, dst;
      logic [8:0] ex;
      r   = ($urandom_range(0, 59) != 0);
      rm  = ($urandom_range(0, 1) != 0);
      dq  = ($urandom_range(0, 3) == 0);
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      dst = 5'($urandom_range(0, 3));
      ex  = ($urandom_range(0, 24) == 0) ? 9'(1 << $urandom_range(0, 8)) : 9'd0;
      drive(r, rs, rt, rm, dst, dq, ex);
    end
    idle(2);
    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
